// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: single-clock FIFO controller sequencing an external sdp_ram.
// A two-entry prefetch buffer hides the RAM read latency (first-word-fall-through).
module fifo_sync_ctrl #(
    parameter int FIFO_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int AFULL_TH        = 14,
    parameter int AEMPTY_TH       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         s_valid,
    input  logic [FIFO_WIDTH-1:0]        s_data,
    output logic                         s_ready,
    output logic                         m_valid,
    output logic [FIFO_WIDTH-1:0]        m_data,
    input  logic                         m_ready,
    output logic [FIFO_ADDR_WIDTH-1:0]   mem_waddr,
    output logic [FIFO_WIDTH-1:0]        mem_wdata,
    output logic                         mem_we,
    output logic [FIFO_ADDR_WIDTH-1:0]   mem_raddr,
    output logic                         mem_re,
    input  logic [FIFO_WIDTH-1:0]        mem_rdata,
    output logic [FIFO_ADDR_WIDTH+1:0]   occupancy,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int AW = FIFO_ADDR_WIDTH;
    localparam int FW = FIFO_WIDTH;
    localparam int OW = AW + 2;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } buf_state_e;

    buf_state_e    state_q, state_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic          inflight_q, inflight_d;
    logic [FW-1:0] head_q, head_d;
    logic [FW-1:0] tail_q, tail_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;

    logic [AW:0]   ram_cnt, ram_cnt_d;
    logic [2:0]    pend;
    logic          push, pop, capture;
    logic [OW-1:0] occ_d;

    assign ram_cnt = wptr_q - rptr_q;
    assign s_ready = (ram_cnt != FULL_CNT) & ~flush;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign capture = inflight_q;

    // Words already owed to the buffer; a pop this cycle frees one slot.
    assign pend   = {1'b0, state_q} + {2'b00, inflight_q};
    assign mem_re = (ram_cnt != '0) & (pend < (3'd2 + {2'b00, pop})) & ~flush;

    assign mem_waddr = wptr_q[AW-1:0];
    assign mem_wdata = s_data;
    assign mem_we    = push;
    assign mem_raddr = rptr_q[AW-1:0];

    assign wptr_d     = flush ? '0 : wptr_q + {{AW{1'b0}}, push};
    assign rptr_d     = flush ? '0 : rptr_q + {{AW{1'b0}}, mem_re};
    assign inflight_d = mem_re;
    assign ram_cnt_d  = wptr_d - rptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= B0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            B0: begin
                if (capture) begin
                    state_d = B1;
                    head_d  = mem_rdata;
                end
            end
            B1: begin
                if (capture && pop) begin
                    head_d = mem_rdata;
                end else if (capture) begin
                    state_d = B2;
                    tail_d  = mem_rdata;
                end else if (pop) begin
                    state_d = B0;
                end
            end
            B2: begin
                if (pop) begin
                    state_d = B1;
                    head_d  = tail_q;
                end
            end
            default: state_d = B0;
        endcase
        if (flush) begin
            state_d = B0;
        end
    end

    always_comb begin
        m_valid   = (state_q != B0);
        m_data    = head_q;
        occupancy = {1'b0, ram_cnt}
                  + {{(OW-1){1'b0}}, inflight_q}
                  + {{(OW-2){1'b0}}, state_q};
        occ_d     = {1'b0, ram_cnt_d}
                  + {{(OW-1){1'b0}}, inflight_d}
                  + {{(OW-2){1'b0}}, state_d};
        afull_d      = (occ_d >= OW'(AFULL_TH));
        aempty_d     = (occ_d <= OW'(AEMPTY_TH));
        almost_full  = afull_q;
        almost_empty = aempty_q;
    end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl: scoreboard bench for fifo_sync_ctrl with a behavioural RAM.
// Directed scenarios followed by randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_fifo_sync_ctrl;

    localparam int FW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic [FW-1:0] s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [FW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic [AW-1:0] mem_waddr;
    logic [FW-1:0] mem_wdata;
    logic          mem_we;
    logic [AW-1:0] mem_raddr;
    logic          mem_re;
    logic [FW-1:0] mem_rdata = '0;
    logic [AW+1:0] occupancy;
    logic          almost_full;
    logic          almost_empty;

    fifo_sync_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_raddr    (mem_raddr),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .occupancy    (occupancy),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    logic [FW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_raddr];
    end

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            acc_total = 0;
    int            pop_cyc[$];
    logic [FW-1:0] expq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Input side: record every accepted word as the expected output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                expq.delete();
            end else if (s_valid && s_ready) begin
                expq.push_back(s_data);
                acc_total++;
            end
        end
    end

    // Output monitor: ordering, data and stall stability.
    logic          stall_v = 1'b0;
    logic [FW-1:0] stall_d = '0;
    always @(negedge clk) begin
        logic [FW-1:0] e;
        if (!rst_n || flush) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_hold", 32'(m_data), 32'(stall_d));
            end
            if (m_valid && m_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL pop_empty: got %0h with no word expected",
                             m_data);
                end else begin
                    e = expq.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL data: got %0h expected %0h", m_data, e);
                    end
                end
                pop_cyc.push_back(cyc);
            end
            stall_v = m_valid && !m_ready;
            stall_d = m_data;
        end
    end

    // Occupancy and threshold flags track the count of stored words.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            chk("occupancy", 32'(occupancy), 32'(expq.size()));
            chk("almost_full", 32'(almost_full), 32'(expq.size() >= 14));
            chk("almost_empty", 32'(almost_empty), 32'(expq.size() <= 2));
        end
    end

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while ((m_valid || expq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_time", 32'(n < budget), 32'd1);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_s_ready"}, 32'(s_ready), 32'd1);
        chk({nm, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({nm, "_m_data"}, 32'(m_data), 32'd0);
        chk({nm, "_mem_re"}, 32'(mem_re), 32'd0);
        chk({nm, "_occ"}, 32'(occupancy), 32'd0);
        chk({nm, "_afull"}, 32'(almost_full), 32'd0);
        chk({nm, "_aempty"}, 32'(almost_empty), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, n, base;
        repeat (3) step();
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Single word latency.
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        #1;
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_waddr", 32'(mem_waddr), 32'd0);
        chk("t1_wdata", 32'(mem_wdata), 32'hA5);
        step();
        s_valid = 1'b0;
        #1;
        chk("t1_re", 32'(mem_re), 32'd1);
        chk("t1_raddr", 32'(mem_raddr), 32'd0);
        chk("t1_mv_e0", 32'(m_valid), 32'd0);
        step();
        chk("t1_mv_e1", 32'(m_valid), 32'd0);
        step();
        chk("t1_mv_e2", 32'(m_valid), 32'd1);
        chk("t1_md_e2", 32'(m_data), 32'hA5);
        step();
        chk("t1_mv_e3", 32'(m_valid), 32'd0);
        chk("t1_aempty", 32'(almost_empty), 32'd1);

        // Fill until full with the consumer stalled.
        m_ready = 1'b0;
        c0 = acc_total;
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i + 16);
            step();
        end
        chk("t2_accepted", 32'(acc_total - c0), 32'd18);
        chk("t2_s_ready", 32'(s_ready), 32'd0);
        chk("t2_occ", 32'(occupancy), 32'd18);
        chk("t2_afull", 32'(almost_full), 32'd1);

        // Toggle the consumer while the buffer is full.
        for (int i = 0; i < 40; i++) begin
            m_ready = i[0];
            s_data  = 8'(100 + i);
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_empty(100);

        // Streaming 0..63 at full rate.
        base = pop_cyc.size();
        for (int i = 0; i < 64; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            chk("t3_s_ready", 32'(s_ready), 32'd1);
            step();
        end
        s_valid = 1'b0;
        wait_empty(20);
        chk("t3_count", 32'(pop_cyc.size() - base), 32'd64);
        if (pop_cyc.size() >= base + 64)
            chk("t3_rate", 32'(pop_cyc[base+63] - pop_cyc[base]), 32'd63);

        // Flush with stored words and a read in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(200 + i);
            step();
        end
        s_valid = 1'b0;
        repeat (5) step();
        m_ready = 1'b1;
        #1;
        chk("t5_re_issue", 32'(mem_re), 32'd1);
        step();
        m_ready = 1'b0;
        chk("t5_occ_pre", 32'(occupancy), 32'd10);
        flush = 1'b1;
        #1;
        chk("t5_fl_ready", 32'(s_ready), 32'd0);
        chk("t5_fl_re", 32'(mem_re), 32'd0);
        step();
        flush = 1'b0;
        chk("t5_occ", 32'(occupancy), 32'd0);
        chk("t5_mv", 32'(m_valid), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'h3C;
        step();
        s_valid = 1'b0;
        n = 0;
        while (!m_valid && n < 10) begin
            step();
            n++;
        end
        chk("t5_first_valid", 32'(m_valid), 32'd1);
        chk("t5_first_data", 32'(m_data), 32'h3C);
        m_ready = 1'b1;
        wait_empty(20);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            m_ready = ($urandom_range(0, 1) == 1);
            step();
        end
        #2;
        rst_n = 1'b0;
        expq.delete();
        #1;
        chk_reset_vals("arst");
        s_valid = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;

        // Randomized traffic with occasional flushes.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 250; i++) begin
                s_valid = ($urandom_range(0, 9) <
                           ((ph % 3 == 0) ? 9 : (ph % 3 == 1) ? 3 : 6));
                m_ready = ($urandom_range(0, 9) <
                           ((ph % 3 == 0) ? 3 : (ph % 3 == 1) ? 9 : 6));
                s_data  = 8'($urandom);
                flush   = ($urandom_range(0, 149) == 0);
                step();
            end
        end
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_empty(100);
        chk("end_occ", 32'(occupancy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
